// File: rtl/div_ctrl.sv
// div_ctrl: run-time programmable clock-enable divider controller.
// A divide ratio N and a burst length are loaded over a valid/ready port. On start the
// block emits a one-cycle tick at the end of every N-cycle period, a divided level (imp)
// and a done pulse on the final tick of the run.
// Every pulse/level output is registered. Each one is computed from the *next* state so
// that it lines up with the phase counter it describes.
module div_ctrl #(
    parameter int DIV_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             tick,
    output logic             imp,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W:0]   HALF_ONE = {{DIV_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [DIV_W-1:0] phase_r, phase_s;
    logic [CNT_W-1:0] rem_r, rem_s;
    logic             stop_pend_r, stop_pend_s;
    logic             tick_r, tick_s;
    logic             imp_r, imp_s;
    logic             done_r, done_s;
    logic             err_r, err_s;

    logic             accept_s;
    logic             cfg_ok_s;
    logic [DIV_W-1:0] eff_div_s;
    logic [CNT_W-1:0] eff_cnt_s;
    logic [DIV_W:0]   half_s;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        cnt_s       = cnt_r;
        phase_s     = phase_r;
        rem_s       = rem_r;
        stop_pend_s = stop_pend_r;
        tick_s      = 1'b0;
        imp_s       = 1'b0;
        done_s      = 1'b0;
        half_s      = {(DIV_W+1){1'b0}};

        // A handshake happens whenever the port is ready. Only a nonzero ratio is latched.
        accept_s  = cfg_valid && (state_r != RUN);
        cfg_ok_s  = accept_s && (cfg_div != DIV_ZERO);
        err_s     = accept_s && (cfg_div == DIV_ZERO);
        // A start that coincides with a fresh config runs with the fresh config.
        eff_div_s = cfg_ok_s ? cfg_div : div_r;
        eff_cnt_s = cfg_ok_s ? cfg_count : cnt_r;

        case (state_r)
            IDLE: begin
                if (cfg_ok_s) begin
                    div_s   = cfg_div;
                    cnt_s   = cfg_count;
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                div_s = eff_div_s;
                cnt_s = eff_cnt_s;
                if (stop) begin
                    state_s = IDLE;
                end else if (start) begin
                    state_s     = RUN;
                    phase_s     = DIV_ZERO;
                    rem_s       = eff_cnt_s;
                    stop_pend_s = 1'b0;
                end else begin
                    state_s = ARMED;
                end
            end
            RUN: begin
                // The run ends after the final tick, or after a tick during which stop is held.
                if (tick_r && (done_r || stop)) begin
                    state_s     = IDLE;
                    phase_s     = DIV_ZERO;
                    rem_s       = CNT_ZERO;
                    stop_pend_s = 1'b0;
                end else begin
                    phase_s     = (phase_r == (div_r - DIV_ONE)) ? DIV_ZERO : (phase_r + DIV_ONE);
                    stop_pend_s = stop_pend_r | stop;
                    if (tick_r && (cnt_r != CNT_ZERO) && (rem_r != CNT_ZERO)) begin
                        rem_s = rem_r - CNT_ONE;
                    end else begin
                        rem_s = rem_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s == RUN) begin
            half_s = ({1'b0, div_s} + HALF_ONE) >> 1;
            tick_s = (phase_s == (div_s - DIV_ONE));
            imp_s  = ({1'b0, phase_s} < half_s);
            done_s = tick_s && (((cnt_s != CNT_ZERO) && (rem_s == CNT_ONE)) || stop_pend_s);
        end else begin
            tick_s = 1'b0;
            imp_s  = 1'b0;
            done_s = 1'b0;
        end
    end

    // State, config, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            div_r       <= DIV_ZERO;
            cnt_r       <= CNT_ZERO;
            phase_r     <= DIV_ZERO;
            rem_r       <= CNT_ZERO;
            stop_pend_r <= 1'b0;
            tick_r      <= 1'b0;
            imp_r       <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            cnt_r       <= cnt_s;
            phase_r     <= phase_s;
            rem_r       <= rem_s;
            stop_pend_r <= stop_pend_s;
            tick_r      <= tick_s;
            imp_r       <= imp_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign cfg_ready = (state_r != RUN);
    assign busy      = (state_r != IDLE);
    assign tick      = tick_r;
    assign imp       = imp_r;
    assign done      = done_r;
    assign cfg_err   = err_r;

endmodule
